// File: rtl/shift_normalizer.sv
// shift_normalizer: iterative left-shift normalizer.
// Takes one operand over a valid/ready handshake and shifts it left one bit
// per clock until normalized. It returns the normalized word, the shift count
// and an all-zero flag.
// Optional feature macro: SHIFT_NORM_SIGNED_EN. When it is defined, in_signed
// selects two's-complement normalization. When it is undefined, every operand
// is normalized unsigned and in_signed is ignored.
module shift_normalizer #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_zero
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             zero_q, zero_d;
  logic             norm;

`ifdef SHIFT_NORM_SIGNED_EN
  logic sgn_q, sgn_d;

  // Signed operands are normalized once the top two bits differ.
  always_comb begin
    norm = sgn_q ? (data_q[WIDTH-1] ^ data_q[WIDTH-2]) : data_q[WIDTH-1];
  end

  // Signed-mode flag, captured together with the operand.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) sgn_q <= 1'b0;
    else       sgn_q <= sgn_d;
  end
`else
  logic unused_in_signed;
  assign unused_in_signed = in_signed;

  // Unsigned only: the operand is normalized once the MSB is set.
  always_comb begin
    norm = data_q[WIDTH-1];
  end
`endif

  // Next-state and datapath update. Zero is checked before normalization,
  // so an all-zero word finishes on the first evaluation.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
`ifdef SHIFT_NORM_SIGNED_EN
    sgn_d   = sgn_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          cnt_d   = '0;
          zero_d  = 1'b0;
`ifdef SHIFT_NORM_SIGNED_EN
          sgn_d   = in_signed;
`endif
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (data_q == '0) begin
          zero_d  = 1'b1;
          cnt_d   = CNT_W'(WIDTH);
          state_d = DONE;
        end else if (norm) begin
          state_d = DONE;
        end else begin
          data_d = {data_q[WIDTH-2:0], 1'b0};
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers. Reset drops any in-flight operand.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
    end
  end

  // All outputs are driven straight from registers or decoded from the state.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = data_q;
  assign out_cnt   = cnt_q;
  assign out_zero  = zero_q;

endmodule

// File: tb/tb_shift_normalizer.sv
// tb_shift_normalizer: randomized and directed bench with a behavioural
// reference model. Results are derived from leading-bit counts; timing is
// derived from latency rules.
module tb_shift_normalizer;
  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);
`ifdef SHIFT_NORM_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_signed = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_ready, out_valid, out_zero;
  logic [W-1:0]  out_data;
  logic [CW-1:0] out_cnt;

  shift_normalizer #(.WIDTH(W)) dut (
    .clk(clk), .nrst(nrst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_signed(in_signed),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_cnt(out_cnt), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference behaviour:
  //  - unsigned: shift count = number of leading zeros.
  //  - signed:   shift count = (length of the leading sign run) - 1.
  //  - zero:     count = W, zero flag set.
  function automatic void ref_norm(input logic [W-1:0] v, input bit sg,
                                   output logic [W-1:0] d, output int c, output bit z);
    int run;
    z = 1'b0;
    run = 0;
    if (v == '0) begin
      d = '0; c = W; z = 1'b1;
      return;
    end
    if (!sg) begin
      for (int i = W - 1; i >= 0; i--) begin
        if (v[i]) break;
        run++;
      end
      c = run;
    end else begin
      for (int i = W - 1; i >= 0; i--) begin
        if (v[i] != v[W-1]) break;
        run++;
      end
      c = run - 1;
    end
    d = v << c;
  endfunction

  // Model of expected handshake timing and results.
  bit           m_busy = 1'b0, m_done = 1'b0, m_rstv = 1'b1;
  int           m_left = 0;
  logic [W-1:0] m_d = '0;
  int           m_c = 0;
  bit           m_z = 1'b0;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_busy = 1'b0; m_done = 1'b0; m_rstv = 1'b1;
    end else if (m_done) begin
      if (out_ready) m_done = 1'b0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin m_busy = 1'b0; m_done = 1'b1; end
    end else if (in_valid) begin
      ref_norm(in_data, in_signed && SIGNED_EN, m_d, m_c, m_z);
      m_left = m_z ? 1 : m_c + 1;
      m_busy = 1'b1;
      m_rstv = 1'b0;
    end
  end

  // Compare the DUT against the model on every falling edge.
  bit chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", 32'(in_ready), 32'(!(m_busy || m_done)));
      chk("out_valid", 32'(out_valid), 32'(m_done));
      if (m_done) begin
        chk("out_data", 32'(out_data), 32'(m_d));
        chk("out_cnt", 32'(out_cnt), 32'(m_c));
        chk("out_zero", 32'(out_zero), 32'(m_z));
      end else if (m_rstv) begin
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_cnt", 32'(out_cnt), 32'd0);
        chk("rst_zero", 32'(out_zero), 32'd0);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [W-1:0] v, input bit sg);
    in_valid = 1'b1; in_data = v; in_signed = sg;
    cyc(1);
    in_valid = 1'b0;
  endtask

  // Count edges from acceptance to out_valid. The wait is bounded.
  task automatic measure(input string nm, input logic [W-1:0] v, input int exp_lat);
    int n;
    n = 0;
    send(v, 1'b0);
    while (!out_valid && n < 3 * W) begin cyc(1); n++; end
    chk(nm, 32'(n), 32'(exp_lat));
    cyc(2);
  endtask

  task automatic pin(input string nm, input logic [W-1:0] v, input bit sg,
                     input logic [W-1:0] ed, input int ec, input bit ez);
    logic [W-1:0] d; int c; bit z;
    ref_norm(v, sg, d, c, z);
    chk({nm, "_d"}, 32'(d), 32'(ed));
    chk({nm, "_c"}, 32'(c), 32'(ec));
    chk({nm, "_z"}, 32'(z), 32'(ez));
  endtask

  function automatic logic [W-1:0] gen();
    logic [W-1:0] t;
    t = W'($urandom);
    case ($urandom % 8)
      0:       return '0;
      1:       return '1;
      default: return t >> $urandom_range(0, W - 1);
    endcase
  endfunction

  initial begin
    // Hand-computed expectations for the model itself.
    pin("pin_u01", 8'h01, 1'b0, 8'h80, 7, 1'b0);
    pin("pin_u80", 8'h80, 1'b0, 8'h80, 0, 1'b0);
    pin("pin_u00", 8'h00, 1'b0, 8'h00, 8, 1'b1);
    pin("pin_u03", 8'h03, 1'b0, 8'hC0, 6, 1'b0);
    pin("pin_s03", 8'h03, 1'b1, 8'h60, 5, 1'b0);
    pin("pin_sFF", 8'hFF, 1'b1, 8'h80, 7, 1'b0);
    pin("pin_sC0", 8'hC0, 1'b1, 8'h80, 1, 1'b0);

    cyc(1);
    chk_en = 1'b1;
    cyc(2);
    @(negedge clk) nrst = 1'b1;
    cyc(1);
    out_ready = 1'b1;

    // Latency corners.
    measure("lat_01", 8'h01, 8);
    measure("lat_80", 8'h80, 1);
    measure("lat_00", 8'h00, 1);

    // Signed operands. The expected result depends on the build.
    send(8'h03, 1'b1); cyc(W + 3);
    send(8'hFF, 1'b1); cyc(W + 3);
    send(8'hC0, 1'b1); cyc(W + 3);

    // Backpressure: result held while in_valid is still offered.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h80; in_signed = 1'b0;
    cyc(1);
    in_data = 8'h11;
    cyc(7);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_out_data", 32'(out_data), 32'h80);
    out_ready = 1'b1;
    cyc(2);
    in_valid = 1'b0;
    cyc(W + 3);

    // Reset in the middle of shifting.
    send(8'h01, 1'b0);
    cyc(3);
    nrst = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_data", 32'(out_data), 32'd0);
    chk("mid_rst_out_cnt", 32'(out_cnt), 32'd0);
    chk("mid_rst_out_zero", 32'(out_zero), 32'd0);
    cyc(2);
    @(negedge clk) nrst = 1'b1;
    cyc(1);
    send(8'h40, 1'b0);
    cyc(W + 3);

    // Randomized traffic with random backpressure.
    repeat (2500) begin
      @(posedge clk); #1;
      in_valid  = ($urandom % 4) != 0;
      in_data   = gen();
      in_signed = $urandom_range(0, 1) == 1;
      out_ready = ($urandom % 3) != 0;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    cyc(W + 4);
    chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
